// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the 5-stage MIPS-subset pipeline.
//
// Holds the IF/ID pipeline register, drives the register-file read
// addresses, decodes the instruction, detects load-use hazards (stalling
// fetch for one cycle) and launches the ID/EX pipeline register.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_valid/if_instr/if_pc    fetched instruction and its byte address
//   flush                      branch/jump resolved in EX, kill younger work
//   stall_if                   hold PC and fetch output (combinational)
//   rf_raddr1/rf_raddr2        rs/rt read addresses (combinational)
//   rf_rdata1/rf_rdata2        register-file read data, same cycle
//   ex_*                       ID/EX register fields toward execute
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,
  output logic        stall_if,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_dest,
  output logic [2:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic [31:0] ex_jtarget,
  output logic        ex_illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [4:0] dest;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic       uses_rs;
    logic       uses_rt;
  } dec_t;

  // IF/ID register
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  dec_t        dec;
  logic [31:0] imm;
  logic [3:0]  pc_plus4_hi;
  logic [31:0] jtarget;
  logic        load_use;
  logic        launch;

  assign opcode = id_instr[31:26];
  assign funct  = id_instr[5:0];
  assign rs     = id_instr[25:21];
  assign rt     = id_instr[20:16];
  assign rd     = id_instr[15:11];

  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  assign imm = {{16{id_instr[15]}}, id_instr[15:0]};

  // Upper nibble of id_pc + 4: adding 4 carries into bit 28 only when
  // bits [27:2] are all ones, so the full 32-bit add is unnecessary.
  assign pc_plus4_hi = id_pc[31:28] + {3'b000, &id_pc[27:2]};
  assign jtarget     = {pc_plus4_hi, id_instr[25:0], 2'b00};

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // signal unassigned; that is what keeps this block free of latches.
    dec = '0;
    if (id_instr != 32'd0) begin
      case (opcode)
        OP_RTYPE: begin
          dec.dest      = rd;
          dec.reg_write = 1'b1;
          dec.uses_rs   = 1'b1;
          dec.uses_rt   = 1'b1;
          case (funct)
            FN_ADD:  dec.alu_op = ALU_ADD;
            FN_SUB:  dec.alu_op = ALU_SUB;
            FN_AND:  dec.alu_op = ALU_AND;
            FN_OR:   dec.alu_op = ALU_OR;
            FN_SLT:  dec.alu_op = ALU_SLT;
            default: begin
              dec         = '0;
              dec.illegal = 1'b1;
            end
          endcase
        end
        OP_ADDI: begin
          dec.alu_src   = 1'b1;
          dec.dest      = rt;
          dec.reg_write = 1'b1;
          dec.uses_rs   = 1'b1;
        end
        OP_LW: begin
          dec.alu_src   = 1'b1;
          dec.mem_read  = 1'b1;
          dec.dest      = rt;
          dec.reg_write = 1'b1;
          dec.uses_rs   = 1'b1;
        end
        OP_SW: begin
          dec.alu_src   = 1'b1;
          dec.mem_write = 1'b1;
          dec.uses_rs   = 1'b1;
          dec.uses_rt   = 1'b1;
        end
        OP_BEQ: begin
          dec.alu_op  = ALU_SUB;
          dec.branch  = 1'b1;
          dec.uses_rs = 1'b1;
          dec.uses_rt = 1'b1;
        end
        OP_J: begin
          dec.jump = 1'b1;
        end
        default: begin
          dec.illegal = 1'b1;
        end
      endcase
    end
  end

  // Only a load sitting in EX can feed ID too late; WB->ID is covered by
  // the register file's write-through bypass.
  assign load_use = id_valid && ex_valid && ex_mem_read && (ex_dest != 5'd0) &&
                    ((dec.uses_rs && (rs == ex_dest)) ||
                     (dec.uses_rt && (rt == ex_dest)));

  assign stall_if = load_use && !flush;
  assign launch   = id_valid && !flush && !load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: pipeline state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (!stall_if) begin
      id_valid <= if_valid;
      id_instr <= if_instr;
      id_pc    <= if_pc;
    end
  end

  // Control bits and ex_valid drop together on a bubble; data fields only
  // move when a real instruction launches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_alu_op    <= '0;
      ex_alu_src   <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jump      <= 1'b0;
      ex_illegal   <= 1'b0;
      ex_pc        <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_dest      <= '0;
      ex_jtarget   <= '0;
    end else if (!launch) begin
      ex_valid     <= 1'b0;
      ex_alu_op    <= '0;
      ex_alu_src   <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jump      <= 1'b0;
      ex_illegal   <= 1'b0;
    end else begin
      ex_valid     <= 1'b1;
      ex_alu_op    <= dec.alu_op;
      ex_alu_src   <= dec.alu_src;
      ex_mem_read  <= dec.mem_read;
      ex_mem_write <= dec.mem_write;
      ex_reg_write <= dec.reg_write;
      ex_branch    <= dec.branch;
      ex_jump      <= dec.jump;
      ex_illegal   <= dec.illegal;
      ex_pc        <= id_pc;
      ex_rs_data   <= rf_rdata1;
      ex_rt_data   <= rf_rdata2;
      ex_imm       <= imm;
      ex_rs        <= rs;
      ex_rt        <= rt;
      ex_dest      <= dec.dest;
      ex_jtarget   <= jtarget;
    end
  end

endmodule
